// File: rtl/types_pkg.sv
// Shared execute-stage types: machine word types and the divider's opcode/state encodings.
package types_pkg;

  localparam int XLEN = 32;

  typedef logic [XLEN-1:0]        word_t;
  typedef logic signed [XLEN-1:0] signed_word_t;

  typedef enum logic [1:0] {
    DIV_DIV,
    DIV_DIVU,
    DIV_REM,
    DIV_REMU
  } divop_e;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_CALC,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

  localparam int DIV_ITER = XLEN;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem,quo} left, trial-subtract the divisor, keep or restore.
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] quo_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] quo_o
);

  logic [XLEN:0] rem_sh;
  logic [XLEN:0] trial;

  // The extra top bit keeps the borrow when the shifted remainder exceeds 2^XLEN-1.
  assign rem_sh = {rem_i, quo_i[XLEN-1]};
  assign trial  = rem_sh - {1'b0, divisor_i};

  always_comb begin
    if (!trial[XLEN]) begin
      rem_o = trial[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = rem_sh[XLEN-1:0];
      quo_o = {quo_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) with start/busy/valid handshake and flush abort.
module div_unit
  import types_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  divop_e          op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            valid,
  output logic [XLEN-1:0] result
);

  div_state_e      state_q, state_d;
  divop_e          op_q, op_d;
  logic            negq_q, negq_d;
  logic            negr_q, negr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            in_signed, in_rem, a_neg, b_neg, div_zero, ovf;
  logic [XLEN-1:0] a_abs, b_abs, fast_res;
  logic [XLEN-1:0] step_rem, step_quo, q_fix, r_fix;

  assign in_signed = (op == DIV_DIV) || (op == DIV_REM);
  assign in_rem    = (op == DIV_REM) || (op == DIV_REMU);
  assign a_neg     = in_signed && a[XLEN-1];
  assign b_neg     = in_signed && b[XLEN-1];
  assign a_abs     = a_neg ? -a : a;
  assign b_abs     = b_neg ? -b : b;
  assign div_zero  = (b == '0);
  assign ovf       = in_signed && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);

  // Overflow quotient equals the dividend itself (0x80000000), remainder is zero.
  always_comb begin
    if (div_zero) fast_res = in_rem ? a : '1;
    else          fast_res = in_rem ? '0 : a;
  end

  div_step #(.XLEN(XLEN)) u_step (
    .rem_i     (rem_q),
    .quo_i     (quo_q),
    .divisor_i (dvs_q),
    .rem_o     (step_rem),
    .quo_o     (step_quo)
  );

  assign q_fix = negq_q ? -quo_q : quo_q;
  assign r_fix = negr_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    cnt_d    = cnt_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    result_d = result_q;
    case (state_q)
      DIV_IDLE: begin
        if (start && !flush) begin
          op_d   = op;
          negq_d = a_neg ^ b_neg;
          negr_d = a_neg;
          if (div_zero || ovf) begin
            result_d = fast_res;
            state_d  = DIV_DONE;
          end else begin
            cnt_d   = CNT_W'(XLEN - 1);
            rem_d   = '0;
            quo_d   = a_abs;
            dvs_d   = b_abs;
            state_d = DIV_CALC;
          end
        end
      end
      DIV_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        if (cnt_q == '0) state_d = DIV_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      DIV_FIX: begin
        result_d = ((op_q == DIV_REM) || (op_q == DIV_REMU)) ? r_fix : q_fix;
        state_d  = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    // Flush beats everything, including a result write that would land this cycle.
    if (flush) begin
      state_d  = DIV_IDLE;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= DIV_IDLE;
      op_q     <= DIV_DIV;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q != DIV_IDLE);
  assign valid  = (state_q == DIV_DONE);
  assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed and randomized scoreboard bench for div_unit: results, latency, fast paths, flush and reset.
module tb_div_unit;
  import types_pkg::*;

  logic        clk = 1'b0;
  logic        rst, start, flush;
  divop_e      op;
  logic [31:0] a, b;
  logic        busy, valid;
  logic [31:0] result;

  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;
  int vld_cnt = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_exp;

  div_unit #(.XLEN(32), .CNT_W(5)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .flush  (flush),
    .busy   (busy),
    .valid  (valid),
    .result (result)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (valid) vld_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input divop_e o, input logic [31:0] x, input logic [31:0] y);
    logic ov;
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    case (o)
      DIV_DIV:  model = (y == 0) ? 32'hFFFF_FFFF : ov ? x : 32'($signed(x) / $signed(y));
      DIV_DIVU: model = (y == 0) ? 32'hFFFF_FFFF : x / y;
      DIV_REM:  model = (y == 0) ? x : ov ? 32'h0 : 32'($signed(x) % $signed(y));
      default:  model = (y == 0) ? x : x % y;
    endcase
  endfunction

  // Launch one operation, then watch for its valid pulse within a bounded window.
  task automatic run_op(input string tag, input divop_e o, input logic [31:0] aa, input logic [31:0] bb,
                        input logic [31:0] ex, input int lat, input bit noise);
    int seen;
    int v0;
    seen = 0;
    v0   = vld_cnt;
    exp_q.push_back(ex);
    op = o; a = aa; b = bb; start = 1'b1;
    for (int k = 1; k <= 60 && seen == 0; k++) begin
      tick();
      start = 1'b0;
      if (k == 1) begin
        a  = $urandom;
        b  = $urandom;
        op = divop_e'($urandom_range(0, 3));
        if (lat > 1) check({tag, "_busy"}, {31'b0, busy}, 32'd1);
      end
      if (noise && (k == 5 || k == 12)) start = 1'b1;
      if (valid) begin
        seen = k;
        check({tag, "_latency"}, k, lat);
        check({tag, "_result"}, result, exp_q.pop_front());
      end
    end
    start = 1'b0;
    if (seen == 0) begin
      check({tag, "_timeout"}, seen, lat);
      void'(exp_q.pop_front());
    end
    tick();
    check({tag, "_valid_drop"}, {31'b0, valid}, 32'd0);
    check({tag, "_pulses"}, vld_cnt - v0, 32'd1);
    last_exp = ex;
  endtask

  initial begin
    logic [31:0] ra, rb;
    divop_e      ro;
    int          v0;
    rst = 1'b1; start = 1'b0; flush = 1'b0; op = DIV_DIV; a = '0; b = '0;
    #3;
    check("reset_busy", {31'b0, busy}, 32'd0);
    check("reset_valid", {31'b0, valid}, 32'd0);
    check("reset_result", result, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    run_op("divu_100_7", DIV_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b0);
    run_op("remu_100_7", DIV_REMU, 32'd100, 32'd7, 32'd2, 34, 1'b0);
    run_op("rem_m7_2", DIV_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34, 1'b0);
    run_op("div_m7_2", DIV_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("divu_max_2", DIV_DIVU, 32'hFFFF_FFFF, 32'd2, 32'h7FFF_FFFF, 34, 1'b0);
    run_op("divu_big", DIV_DIVU, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 34, 1'b0);
    run_op("remu_big", DIV_REMU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34, 1'b0);
    run_op("div_5_0", DIV_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
    run_op("remu_5_0", DIV_REMU, 32'd5, 32'd0, 32'd5, 1, 1'b0);
    run_op("rem_m9_0", DIV_REM, 32'hFFFF_FFF7, 32'd0, 32'hFFFF_FFF7, 1, 1'b0);
    run_op("div_ovf", DIV_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
    run_op("rem_ovf", DIV_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 1'b0);
    run_op("div_7_m2", DIV_DIV, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 34, 1'b0);
    run_op("rem_7_m2", DIV_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 34, 1'b0);

    // Flush mid-CALC: no pulse, result keeps the previous value.
    v0 = vld_cnt;
    op = DIV_DIVU; a = 32'd1000; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy", {31'b0, busy}, 32'd0);
    check("flush_valid", {31'b0, valid}, 32'd0);
    check("flush_result", result, last_exp);
    run_op("divu_9_3", DIV_DIVU, 32'd9, 32'd3, 32'd3, 34, 1'b0);
    check("flush_no_pulse", vld_cnt - v0, 32'd1);

    // Flush and start together in IDLE: nothing accepted.
    v0 = vld_cnt;
    op = DIV_DIV; a = 32'd5; b = 32'd0; start = 1'b1; flush = 1'b1;
    tick();
    start = 1'b0; flush = 1'b0;
    check("fs_idle_busy", {31'b0, busy}, 32'd0);
    tick();
    check("fs_idle_pulses", vld_cnt - v0, 32'd0);
    check("fs_idle_result", result, last_exp);

    // Flush while DONE presents valid: the pulse already shown stays.
    op = DIV_DIVU; a = 32'd77; b = 32'd0; start = 1'b1;
    tick();
    start = 1'b0;
    flush = 1'b1;
    #1;
    check("flush_done_valid", {31'b0, valid}, 32'd1);
    check("flush_done_result", result, 32'hFFFF_FFFF);
    tick();
    flush = 1'b0;
    check("flush_done_after", {30'b0, valid, busy}, 32'd0);
    last_exp = 32'hFFFF_FFFF;

    // Extra start pulses while busy must be ignored.
    run_op("div_noise", DIV_DIV, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, 34, 1'b1);
    run_op("remu_noise", DIV_REMU, 32'd1000, 32'd7, 32'd6, 34, 1'b1);

    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, 28);
      if (rb == 0) rb = 32'd3;
      if (rb == 32'hFFFF_FFFF) rb = 32'd5;
      ro = divop_e'(i % 4);
      run_op("random", ro, ra, rb, model(ro, ra, rb), 34, 1'b0);
    end

    // Asynchronous reset between edges during CALC.
    op = DIV_DIVU; a = 32'd12345; b = 32'd17; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (5) tick();
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", {31'b0, busy}, 32'd0);
    check("async_rst_valid", {31'b0, valid}, 32'd0);
    check("async_rst_result", result, 32'd0);
    v0 = vld_cnt;
    @(negedge clk);
    rst = 1'b0;
    repeat (40) tick();
    check("async_rst_no_pulse", vld_cnt - v0, 32'd0);
    run_op("after_rst", DIV_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 34, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider implementing RV32M DIV, DIVU, REM and REMU.
- Sits in the execute stage beside the combinational ALU. The ALU covers single-cycle operations; div_unit covers the multi-cycle division path.
- Start/busy/valid handshake; hazard control stalls the pipeline while busy=1.
- Execute-stage flush aborts an in-flight operation.

Parameters:
- XLEN, 32, operand and result width in bits.
- CNT_W, $clog2(XLEN), width of the iteration counter.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  divop_e (2)  DIV, DIVU, REM or REMU.
- a  input  XLEN  dividend (rs1).
- b  input  XLEN  divisor (rs2).
- flush  input  1  abort the current operation.
- busy  output  1  high in every state except IDLE.
- valid  output  1  one-cycle pulse; result is valid during this cycle.
- result  output  XLEN  quotient or remainder, selected by op.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous, active-high.
- Reset values: state=IDLE, busy=0, valid=0, result=0; all internal registers cleared.
- Reset asserted mid-operation returns the unit to IDLE immediately. No valid is produced for the aborted operation.
- States and transitions:
  - IDLE -> CALC: start=1, flush=0, b!=0, and not signed overflow.
  - IDLE -> DONE: start=1, flush=0, and either b==0 or signed overflow.
  - CALC -> FIX: after exactly XLEN iterations.
  - FIX -> DONE: unconditionally.
  - DONE -> IDLE: unconditionally.
- On accept, latch op and the operand signs. For DIV/REM take |a| and |b|; for DIVU/REMU use the operands unchanged. Load counter=XLEN-1, remainder register=0, quotient register=|a|.
- Each CALC cycle performs one restoring step:
  - Shift {rem,quo} left by 1.
  - Form trial = rem - |b| at XLEN+1 bits.
  - If trial is non-negative: rem=trial[XLEN-1:0] and quo[0]=1; otherwise quo[0]=0.
  - Decrement the counter; leave CALC when the counter reaches 0 in that cycle.
- FIX, signed ops only:
  - Quotient is negated iff sign(a)!=sign(b).
  - Remainder is negated iff sign(a)=1.
  - Result register is loaded with the quotient or remainder selected by op.
- DONE asserts valid=1 for exactly one cycle. result holds its value until the next accepted operation writes it; it is not cleared.
- Latency (start high in cycle N):
  - Normal operation: valid in cycle N+34 (CALC occupies N+1..N+32, FIX N+33).
  - Fast path: valid in cycle N+1.
- Division by zero (fast path):
  - DIV/DIVU -> all ones (0xFFFFFFFF).
  - REM/REMU -> a.
- Signed overflow (DIV or REM with a=0x80000000, b=0xFFFFFFFF, fast path):
  - DIV -> 0x80000000.
  - REM -> 0.
- Boundary rules:
  - start while busy=1 is ignored; the operand inputs need not be held stable after acceptance.
  - flush=1 in any state: next state IDLE, valid=0 on the following cycle, result unchanged.
  - flush and start both high in IDLE: flush wins and nothing is accepted.
  - flush during DONE does not retract the valid already presented in that cycle.
  - Unsigned operands with the MSB set (e.g. 0xFFFFFFFF) must not be sign-interpreted. Trial subtraction uses XLEN+1 bits to avoid loss of the borrow.

Decomposition:
- Additions to types_pkg:
  - divop_e enum {DIV_DIV, DIV_DIVU, DIV_REM, DIV_REMU}.
  - div_state_e enum {DIV_IDLE, DIV_CALC, DIV_FIX, DIV_DONE}.
  - DIV_ITER constant = XLEN.
- Reuse word_t and signed_word_t from types_pkg.
- One sub-module, div_step: purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - Isolates the arithmetic for unit testing; the FSM, counter and sign fix stay in div_unit.

Test Plan:
- DIVU a=100, b=7, start at cycle N -> busy=1 from N+1; valid=1 only in N+34 with result=14; REMU same operands -> 2.
- REM a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFF (-1); DIV same operands -> 0xFFFFFFFD (-3); DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF.
- DIV a=5, b=0 -> valid at N+1, result=0xFFFFFFFF; REMU a=5, b=0 -> result=5 at N+1.
- DIV a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 at N+1; REM same operands -> 0.
- flush asserted at N+10 during DIVU 1000/3 -> busy=0 at N+11, no valid pulse, result keeps its prior value. New start DIVU 9/3 at N+12 -> result=3 at N+46.
- rst pulsed mid-CALC, asynchronously between edges -> busy, valid and result go to 0 immediately. start pulses while busy=1 -> ignored, and the original operation completes with the correct result.
